// File: rtl/hazard_controller.sv
// hazard_controller
// Pipeline hazard and stall controller for a 5-stage core.
// Produces write-enable, bubble and flush controls for the PC and the
// IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use
// hazards, squashes younger instructions on a taken branch, and holds
// multi-cycle mul/div operations in EX. It freezes the pipeline while data
// memory is not ready, and keeps saturating stall and flush counters.
//
// Parameters:
//   MULDIV_LAT : total cycles a mul/div occupies EX (2..16)
//   CNT_W      : width of the performance counters
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_id_rs/rt, if_id_uses_rs/rt sources read by the instruction in ID
//   id_ex_mem_read, id_ex_write_reg, id_ex_muldiv  instruction in EX
//   ex_branch_taken               taken branch/jump resolved in EX
//   ex_mem_mem_access, dmem_ready data memory handshake for MEM
//   pc_write .. ex_mem_write      register load enables (1 = advance)
//   if_id_flush, *_bubble         NOP insertion controls
//   muldiv_busy                   mul/div held in EX this cycle
//   stall_cycles, flush_count     saturating performance counters
module hazard_controller #(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       if_id_rs,
  input  logic [2:0]       if_id_rt,
  input  logic             if_id_uses_rs,
  input  logic             if_id_uses_rt,
  input  logic             id_ex_mem_read,
  input  logic [2:0]       id_ex_write_reg,
  input  logic             id_ex_muldiv,
  input  logic             ex_branch_taken,
  input  logic             ex_mem_mem_access,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             mem_wb_bubble,
  output logic             muldiv_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_MULDIV = 1'b1
  } state_t;

  // The entry cycle is the first busy cycle, so the counter covers the
  // remaining MULDIV_LAT-2 busy cycles before the release cycle.
  localparam logic [3:0] LP_CNT_LOAD = 4'(MULDIV_LAT - 2);

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_next;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;
  logic             w_flush_inc;
  logic             w_mem_stall;
  logic             w_load_use;

  assign w_mem_stall = ex_mem_mem_access & ~dmem_ready;

  // A load into r0 never creates a real dependency.
  assign w_load_use = id_ex_mem_read & (id_ex_write_reg != 3'd0) &
                      ((if_id_uses_rs & (if_id_rs == id_ex_write_reg)) |
                       (if_id_uses_rt & (if_id_rt == id_ex_write_reg)));

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_bubble = 1'b0;
    muldiv_busy   = 1'b0;
    w_flush_inc   = 1'b0;
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;

    if (rst) begin
      w_state_next = ST_RUN;
      w_cnt_next   = 4'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mem_stall) begin
            // Full freeze; MEM/WB gets NOPs while the access is pending.
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
          end else if (id_ex_muldiv) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            muldiv_busy   = 1'b1;
            w_cnt_next    = LP_CNT_LOAD;
            w_state_next  = ST_MULDIV;
          end else if (ex_branch_taken) begin
            // Squashing ID also removes any load-use consumer.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            w_flush_inc  = 1'b1;
          end else if (w_load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        ST_MULDIV: begin
          if (r_cnt != 4'd0) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            muldiv_busy   = 1'b1;
            w_cnt_next    = r_cnt - 4'd1;
          end else begin
            // Release cycle: EX/MEM captures the result.
            w_state_next = ST_RUN;
          end
        end
        default: begin
          w_state_next = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_cnt          <= 4'd0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (!pc_write && !(&r_stall_cycles)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (w_flush_inc && !(&r_flush_count)) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule
